heightdiv_n: RTL and testbench
==============================

HEIGHTDIV_N -- requirements
Module: heightdiv_n

Interface
REQ-001 SHALL have parameter NCH, default 2: number of downstream channels, legal range 2..8.
REQ-002 SHALL have parameter WUSZ, default 64: workunit width.
REQ-003 SHALL have parameter AMPSZ, default 32: signed amplitude width.
REQ-004 SHALL have parameter SEL_LSB, default 0: LSB of the branch-select field in a workunit; field width CW = max(1, clog2(NCH)).
REQ-005 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles (used only under REQ-031).
REQ-006 SHALL have port clk  in  1  single clock, all logic on the rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports upstream_req  in  WUSZ and upstream_req_valid  in  1: incoming workunit.
REQ-009 SHALL have port upstream_req_ready  out  1: high only in IDLE.
REQ-010 SHALL have ports upstream_rply  out  AMPSZ and upstream_rply_valid  out  1: combined amplitude.
REQ-011 SHALL have ports downstream_req  out  NCH*WUSZ and downstream_req_valid  out  NCH: channel i occupies slice i.
REQ-012 SHALL have ports downstream_rply  in  NCH*AMPSZ and downstream_rply_valid  in  NCH.
REQ-013 SHALL have ports busy  out  1 (state != IDLE), err  out  1 (sticky protocol error) and timed_out  out  1 (sticky).

Function
REQ-014 SHALL implement states IDLE, ISSUE, COLLECT and REPLY.
REQ-015 IDLE: when upstream_req_valid is high, SHALL latch upstream_req, clear the accumulator and received mask, and go to ISSUE.
REQ-016 ISSUE: for exactly one cycle, SHALL drive all downstream_req_valid bits high, with downstream_req slice i equal to the latched workunit except bits [SEL_LSB +: CW] = i; then go to COLLECT.
REQ-017 Downstream channels always accept; there is no downstream ready.
REQ-018 COLLECT: each cycle, SHALL add every valid reply from a not-yet-received channel into an accumulator of AMPSZ+CW bits, sign-extended.
REQ-019 Multiple channels replying in the same cycle SHALL all be summed in that cycle.
REQ-020 A repeat reply from an already-received channel SHALL be discarded and SHALL set err.
REQ-021 A reply arriving outside COLLECT SHALL be discarded and SHALL set err.
REQ-022 The cycle after all NCH channels are received, SHALL enter REPLY and drive upstream_rply_valid high for one cycle, with upstream_rply equal to the accumulator saturated to signed AMPSZ; then return to IDLE.
REQ-023 Latency: acceptance at cycle T gives downstream valid at T+1; if the last reply arrives at cycle R, upstream_rply_valid is high at R+1.
REQ-024 Back-to-back operation: upstream_req_ready SHALL be high again in the cycle after REPLY.
REQ-025 When not valid, upstream_rply and downstream_req SHALL be driven to 0.

Reset
REQ-026 When rst is low, SHALL asynchronously enter IDLE and clear the accumulator, received mask, err, timed_out and watchdog counter.
REQ-027 During reset, SHALL hold all valid outputs and data outputs at 0 and upstream_req_ready at 0; upstream_req_ready rises in the first clock after deassertion.
REQ-028 Reset mid-operation SHALL abandon the transaction without emitting a reply.

Configuration
REQ-029 Macro HEIGHTDIV_N_TIMEOUT_EN SHALL enable the watchdog.
REQ-030 Without HEIGHTDIV_N_TIMEOUT_EN: timed_out SHALL be constant 0, no counter SHALL be synthesised, and COLLECT SHALL wait indefinitely.
REQ-031 With HEIGHTDIV_N_TIMEOUT_EN: the counter SHALL clear on entering COLLECT and increment each COLLECT cycle. On reaching TIMEOUT it SHALL set timed_out and go to REPLY, emitting the saturated partial sum.

Structure
REQ-032 Package heightdiv_pkg SHALL hold the state enum, the CW computation and the saturate function.
REQ-033 Sub-module amp_accum SHALL hold the masked multi-channel adder, the received mask and the saturation logic.

Verification
REQ-034 NCH=2, wu=0x10: replies ch0=5 at T+3 and ch1=-2 at T+5 -> rply=3 valid at T+6; downstream wu = 0x10 and 0x11.
REQ-035 NCH=4, all replies in one cycle (1,2,3,4) -> one rply=10 the next cycle.
REQ-036 AMPSZ=8, NCH=4, each reply 100 -> rply=127; each reply -100 -> rply=-128.
REQ-037 Duplicate ch0 reply in COLLECT -> err=1 and sum unchanged; a stray reply in IDLE -> err=1 and no rply.
REQ-038 rst low in COLLECT with one reply collected -> no rply, busy=0, upstream_req_ready=1 one clock after release.
REQ-039 With the macro, TIMEOUT=8 and only ch0=7 received -> timed_out=1 and rply=7 at COLLECT entry+9; without the macro -> still busy at +100.

Source files
------------

// File: rtl/heightdiv_pkg.sv
// heightdiv_pkg: shared types and helpers for the heightdiv_n fan-out/fan-in block.
package heightdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_REPLY   = 2'd3
    } state_t;

    // Widest amplitude the saturate helper can handle; callers cast the result down.
    localparam int SAT_W = 128;

    // Branch-select field width: clog2 of the channel count, never below one bit.
    function automatic int calc_cw(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

    // Clamp a signed value into the signed range of amp_w bits.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                         input int amp_w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (amp_w - 1)) - one;
        lo  = -(one <<< (amp_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/heightdiv_n_amp_accum.sv
// amp_accum: masked multi-channel reply adder with received mask and saturated result.
// Only the first reply per channel is summed; repeats are flagged through dup.
module amp_accum #(
    parameter int NCH   = 2,
    parameter int AMPSZ = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [NCH*AMPSZ-1:0] rply_data,
    input  logic [NCH-1:0]       rply_valid,
    output logic                 all_rcvd,
    output logic                 dup,
    output logic [AMPSZ-1:0]     sat_sum
);
    import heightdiv_pkg::*;

    localparam int CW   = calc_cw(NCH);
    localparam int ACCW = AMPSZ + CW;

    logic [NCH-1:0]         mask_q;
    logic signed [ACCW-1:0] acc_q;
    logic [NCH-1:0]         fresh;
    logic signed [ACCW-1:0] inc;

    // Sum all first-time replies of this cycle, each sign-extended to the accumulator width.
    always_comb begin
        fresh = enable ? (rply_valid & ~mask_q) : '0;
        inc   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (fresh[i]) begin
                inc = inc + {{CW{rply_data[i*AMPSZ + AMPSZ - 1]}}, rply_data[i*AMPSZ +: AMPSZ]};
            end
        end
    end

    assign all_rcvd = &(mask_q | fresh);
    assign dup      = enable && (|(rply_valid & mask_q));
    assign sat_sum  = AMPSZ'(saturate(SAT_W'(acc_q), AMPSZ));

    // Accumulator and received mask; cleared when a new workunit is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            acc_q  <= '0;
        end else if (clear) begin
            mask_q <= '0;
            acc_q  <= '0;
        end else if (enable) begin
            mask_q <= mask_q | fresh;
            acc_q  <= acc_q + inc;
        end
    end

endmodule

// File: rtl/heightdiv_n.sv
// heightdiv_n: splits one workunit across NCH channels and returns the saturated sum
// of their amplitude replies. Define HEIGHTDIV_N_TIMEOUT_EN to enable the COLLECT watchdog.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | ready for a workunit (ready held low the first cycle after reset)
// ST_ISSUE   | one-cycle broadcast of per-channel workunits
// ST_COLLECT | summing replies until every channel answered (or watchdog fires)
// ST_REPLY   | one-cycle saturated reply upstream
module heightdiv_n #(
    parameter int NCH     = 2,
    parameter int WUSZ    = 64,
    parameter int AMPSZ   = 32,
    parameter int SEL_LSB = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WUSZ-1:0]      upstream_req,
    input  logic                 upstream_req_valid,
    output logic                 upstream_req_ready,
    output logic [AMPSZ-1:0]     upstream_rply,
    output logic                 upstream_rply_valid,
    output logic [NCH*WUSZ-1:0]  downstream_req,
    output logic [NCH-1:0]       downstream_req_valid,
    input  logic [NCH*AMPSZ-1:0] downstream_rply,
    input  logic [NCH-1:0]       downstream_rply_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 timed_out
);
    import heightdiv_pkg::*;

    localparam int CW = calc_cw(NCH);

    if (NCH < 2 || NCH > 8 || TIMEOUT < 1) begin : g_param_check
        $error("heightdiv_n: NCH must be 2..8 and TIMEOUT must be positive");
    end

    state_t          state_q;
    logic [WUSZ-1:0] wu_q;
    logic            ds_valid_q;
    logic            rply_valid_q;
    logic            ready_q;
    logic            err_q;
    logic            accept;
    logic            acc_en;
    logic            all_rcvd;
    logic            dup;
    logic            stray;
    logic            timeout_hit;
    logic [AMPSZ-1:0] sat_sum;

    assign accept = (state_q == ST_IDLE) && ready_q && upstream_req_valid;
    assign acc_en = (state_q == ST_COLLECT);
    assign stray  = (state_q != ST_COLLECT) && (|downstream_rply_valid);

    amp_accum #(.NCH(NCH), .AMPSZ(AMPSZ)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .enable     (acc_en),
        .rply_data  (downstream_rply),
        .rply_valid (downstream_rply_valid),
        .all_rcvd   (all_rcvd),
        .dup        (dup),
        .sat_sum    (sat_sum)
    );

`ifdef HEIGHTDIV_N_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt_q;
    logic          to_q;

    assign timeout_hit = (state_q == ST_COLLECT) && (wd_cnt_q == TW'(TIMEOUT));
    assign timed_out   = to_q;

    // Watchdog: zeroed in ISSUE so it reads 0 on COLLECT entry, then counts COLLECT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            to_q     <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE) begin
                wd_cnt_q <= '0;
            end else if ((state_q == ST_COLLECT) && !timeout_hit) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (timeout_hit && !all_rcvd) begin
                to_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // Control FSM with registered handshake outputs and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wu_q         <= '0;
            ds_valid_q   <= 1'b0;
            rply_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ds_valid_q   <= 1'b0;
            rply_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wu_q       <= upstream_req;
                        ds_valid_q <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= ST_ISSUE;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (all_rcvd || timeout_hit) begin
                        rply_valid_q <= 1'b1;
                        state_q      <= ST_REPLY;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
            if (dup || stray) begin
                err_q <= 1'b1;
            end
        end
    end

    // Per-channel workunit: latched workunit with the select field replaced by the channel index.
    always_comb begin
        downstream_req = '0;
        if (ds_valid_q) begin
            for (int i = 0; i < NCH; i++) begin
                downstream_req[i*WUSZ +: WUSZ]           = wu_q;
                downstream_req[i*WUSZ + SEL_LSB +: CW]   = CW'(i);
            end
        end
    end

    assign downstream_req_valid = {NCH{ds_valid_q}};
    assign upstream_req_ready   = ready_q;
    assign upstream_rply_valid  = rply_valid_q;
    assign upstream_rply        = rply_valid_q ? sat_sum : '0;
    assign busy                 = (state_q != ST_IDLE);
    assign err                  = err_q;

endmodule

// File: tb/tb_heightdiv_n.sv
// tb_heightdiv_n: directed checks on two configurations of heightdiv_n
// (NCH=2/AMPSZ=32 and NCH=4/AMPSZ=8 with a non-zero select offset).
module tb_heightdiv_n;

    logic clk;
    logic rst;

    // NCH=2, WUSZ=64, AMPSZ=32, SEL_LSB=0, TIMEOUT=8
    logic [63:0]  u2_req;
    logic         u2_vld;
    logic         u2_rdy;
    logic [31:0]  u2_rply;
    logic         u2_rv;
    logic [127:0] d2_req;
    logic [1:0]   d2_dv;
    logic [63:0]  d2_rply;
    logic [1:0]   d2_rv;
    logic         busy2, err2, to2;

    // NCH=4, WUSZ=16, AMPSZ=8, SEL_LSB=4, TIMEOUT=8
    logic [15:0]  u4_req;
    logic         u4_vld;
    logic         u4_rdy;
    logic [7:0]   u4_rply;
    logic         u4_rv;
    logic [63:0]  d4_req;
    logic [3:0]   d4_dv;
    logic [31:0]  d4_rply;
    logic [3:0]   d4_rv;
    logic         busy4, err4, to4;

    int n_cmp = 0;
    int n_bad = 0;

    heightdiv_n #(.NCH(2), .WUSZ(64), .AMPSZ(32), .SEL_LSB(0), .TIMEOUT(8)) u_dut2 (
        .clk(clk), .rst(rst),
        .upstream_req(u2_req), .upstream_req_valid(u2_vld), .upstream_req_ready(u2_rdy),
        .upstream_rply(u2_rply), .upstream_rply_valid(u2_rv),
        .downstream_req(d2_req), .downstream_req_valid(d2_dv),
        .downstream_rply(d2_rply), .downstream_rply_valid(d2_rv),
        .busy(busy2), .err(err2), .timed_out(to2)
    );

    heightdiv_n #(.NCH(4), .WUSZ(16), .AMPSZ(8), .SEL_LSB(4), .TIMEOUT(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .upstream_req(u4_req), .upstream_req_valid(u4_vld), .upstream_req_ready(u4_rdy),
        .upstream_rply(u4_rply), .upstream_rply_valid(u4_rv),
        .downstream_req(d4_req), .downstream_req_valid(d4_dv),
        .downstream_rply(d4_rply), .downstream_rply_valid(d4_rv),
        .busy(busy4), .err(err4), .timed_out(to4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One NCH=4 transaction with all replies in the first COLLECT cycle.
    task automatic run4(input string tag, input logic [15:0] wu, input logic [31:0] rp,
                        input logic [7:0] exp);
        logic [63:0] exp_req;
        for (int i = 0; i < 4; i++) begin
            exp_req[i*16 +: 16]     = wu;
            exp_req[i*16 + 4 +: 2]  = 2'(i);
        end
        u4_req = wu;
        u4_vld = 1'b1;
        cyc();
        u4_vld = 1'b0;
        chk({tag, "_dv"}, d4_dv, 4'hF);
        chk({tag, "_dreq"}, d4_req, exp_req);
        cyc();
        d4_rply = rp;
        d4_rv   = 4'hF;
        cyc();
        d4_rv = 4'h0;
        chk({tag, "_rv"}, u4_rv, 1'b1);
        chk({tag, "_rply"}, u4_rply, exp);
        cyc();
        chk({tag, "_rv_low"}, u4_rv, 1'b0);
        chk({tag, "_ready"}, u4_rdy, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        u2_req = '0; u2_vld = 1'b0; d2_rply = '0; d2_rv = '0;
        u4_req = '0; u4_vld = 1'b0; d4_rply = '0; d4_rv = '0;

        // Reset state
        repeat (3) cyc();
        chk("rst_ready2", u2_rdy, 1'b0);
        chk("rst_ready4", u4_rdy, 1'b0);
        chk("rst_rv2", u2_rv, 1'b0);
        chk("rst_dv2", d2_dv, 2'b00);
        chk("rst_busy2", busy2, 1'b0);
        chk("rst_err2", err2, 1'b0);
        chk("rst_to2", to2, 1'b0);
        rst = 1'b1;
        cyc();
        chk("ready_after_rst2", u2_rdy, 1'b1);
        chk("ready_after_rst4", u4_rdy, 1'b1);

        // NCH=2 basic: wu=0x10, ch0=5 at T+3, ch1=-2 at T+5, reply 3 at T+6
        u2_req = 64'h10; u2_vld = 1'b1;              // T
        cyc(); u2_vld = 1'b0;                        // T+1
        chk("b2_dv", d2_dv, 2'b11);
        chk("b2_dreq", d2_req, {64'h11, 64'h10});
        chk("b2_ready_low", u2_rdy, 1'b0);
        chk("b2_busy", busy2, 1'b1);
        cyc();                                       // T+2
        chk("b2_dv_low", d2_dv, 2'b00);
        chk("b2_dreq_zero", d2_req, 128'h0);
        cyc();                                       // T+3
        d2_rply = {32'h0, 32'd5}; d2_rv = 2'b01;
        cyc(); d2_rv = 2'b00;                        // T+4
        cyc();                                       // T+5
        chk("b2_no_early_rply", u2_rv, 1'b0);
        d2_rply = {32'hFFFF_FFFE, 32'h0}; d2_rv = 2'b10;
        cyc(); d2_rv = 2'b00;                        // T+6
        chk("b2_rv", u2_rv, 1'b1);
        chk("b2_rply", u2_rply, 32'd3);
        cyc();                                       // T+7
        chk("b2_rv_low", u2_rv, 1'b0);
        chk("b2_rply_zero", u2_rply, 32'h0);
        chk("b2_ready_again", u2_rdy, 1'b1);
        chk("b2_idle", busy2, 1'b0);
        chk("b2_no_err", err2, 1'b0);

        // NCH=4: simultaneous replies, then positive and negative saturation
        run4("sum4", 16'hABCD, {8'd4, 8'd3, 8'd2, 8'd1}, 8'd10);
        run4("satp4", 16'h0000, {4{8'h64}}, 8'h7F);
        run4("satn4", 16'hFFFF, {4{8'h9C}}, 8'h80);
        chk("sat4_no_err", err4, 1'b0);

        // Stray reply in IDLE on the NCH=4 instance
        d4_rply = 32'h0000_0011; d4_rv = 4'b0001;
        cyc(); d4_rv = 4'h0;
        chk("stray_err", err4, 1'b1);
        chk("stray_no_rply", u4_rv, 1'b0);
        chk("stray_idle", busy4, 1'b0);
        cyc();
        chk("stray_no_rply2", u4_rv, 1'b0);

        // Duplicate ch0 reply during COLLECT on NCH=2
        u2_req = 64'h20; u2_vld = 1'b1;              // T
        cyc(); u2_vld = 1'b0;                        // T+1
        cyc();                                       // T+2 COLLECT
        d2_rply = {32'h0, 32'd9}; d2_rv = 2'b01;
        cyc();                                       // T+3 duplicate
        d2_rply = {32'h0, 32'd50}; d2_rv = 2'b01;
        cyc(); d2_rv = 2'b00;                        // T+4
        chk("dup_err", err2, 1'b1);
        chk("dup_busy", busy2, 1'b1);
        chk("dup_no_rply", u2_rv, 1'b0);
        d2_rply = {32'd1, 32'h0}; d2_rv = 2'b10;
        cyc(); d2_rv = 2'b00;                        // T+5
        chk("dup_rv", u2_rv, 1'b1);
        chk("dup_sum", u2_rply, 32'd10);
        cyc();

        // Reset in COLLECT with one reply collected
        u2_req = 64'h30; u2_vld = 1'b1;
        cyc(); u2_vld = 1'b0;
        cyc();
        d2_rply = {32'h0, 32'd5}; d2_rv = 2'b01;
        cyc(); d2_rv = 2'b00;
        chk("pre_rst_busy", busy2, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy2, 1'b0);
        chk("midrst_rv", u2_rv, 1'b0);
        chk("midrst_ready", u2_rdy, 1'b0);
        chk("midrst_err_clr", err2, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("postrst_ready", u2_rdy, 1'b1);
        chk("postrst_rv", u2_rv, 1'b0);
        chk("postrst_busy", busy2, 1'b0);
        cyc();
        chk("postrst_rv2", u2_rv, 1'b0);

        // Watchdog: only ch0=7 arrives, at COLLECT entry E
        u2_req = 64'h40; u2_vld = 1'b1;
        cyc(); u2_vld = 1'b0;                        // ISSUE
        cyc();                                       // E
        d2_rply = {32'h0, 32'd7}; d2_rv = 2'b01;
        cyc(); d2_rv = 2'b00;                        // E+1
`ifdef HEIGHTDIV_N_TIMEOUT_EN
        repeat (7) cyc();                            // E+8
        chk("wd_not_yet", u2_rv, 1'b0);
        chk("wd_to_not_yet", to2, 1'b0);
        cyc();                                       // E+9
        chk("wd_rv", u2_rv, 1'b1);
        chk("wd_rply", u2_rply, 32'd7);
        chk("wd_timed_out", to2, 1'b1);
        cyc();
        chk("wd_ready", u2_rdy, 1'b1);
`else
        repeat (99) cyc();                           // E+100
        chk("nowd_busy", busy2, 1'b1);
        chk("nowd_no_rply", u2_rv, 1'b0);
        chk("nowd_to_zero", to2, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
